// File: rtl/rop_req_sched_pkg.sv
// Shared types and constants for the ROP request scheduler.
package rop_req_sched_pkg;

  localparam int ROP_DIM_BITS   = 12;
  localparam int ROP_DEPTH_BITS = 24;
  localparam int ROP_NUM_INPUTS = 4;
  localparam int ROP_SRC_BITS   = (ROP_NUM_INPUTS > 1) ? $clog2(ROP_NUM_INPUTS) : 1;

  typedef struct packed {
    logic [ROP_DIM_BITS-1:0]   pos_x;
    logic [ROP_DIM_BITS-1:0]   pos_y;
    logic [31:0]               color;
    logic [ROP_DEPTH_BITS-1:0] depth;
    logic                      backface;
    logic [ROP_SRC_BITS-1:0]   src;
  } rop_frag_t;

  typedef enum logic {
    ROP_SCHED_IDLE   = 1'b0,
    ROP_SCHED_SERIAL = 1'b1
  } rop_sched_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rop_req_sched_rr_arbiter.sv
// Round-robin grant over request valids; the pointer moves past each granted source.
module rop_req_sched_rr_arbiter
  import rop_req_sched_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_BITS = clog2_min1(N)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [N-1:0]        i_valid,
  output logic [N-1:0]        o_grant,
  output logic                o_grant_valid,
  output logic [IDX_BITS-1:0] o_grant_idx
);

  logic [IDX_BITS-1:0] r_ptr;
  logic [IDX_BITS-1:0] w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!o_grant_valid && i_en && i_valid[w_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
      w_idx = (w_idx == IDX_BITS'(N-1)) ? '0 : w_idx + IDX_BITS'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= (o_grant_idx == IDX_BITS'(N-1)) ? '0 : o_grant_idx + IDX_BITS'(1);
    end
  end

endmodule

// File: rtl/rop_req_sched.sv
// ROP front-end: arbitrates warp requests and serialises active lanes into fragments.
// Optional ROP_SCHED_PERF_EN adds stall and fragment handshake counters.
module rop_req_sched
  import rop_req_sched_pkg::*;
#(
  parameter int NUM_INPUTS  = ROP_NUM_INPUTS,
  parameter int NUM_THREADS = 4,
  parameter int DIM_BITS    = ROP_DIM_BITS,
  parameter int DEPTH_BITS  = ROP_DEPTH_BITS,
  parameter int SRC_BITS    = clog2_min1(NUM_INPUTS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_INPUTS-1:0]                  req_valid,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]      req_tmask,
  input  logic [NUM_INPUTS*NUM_THREADS*DIM_BITS-1:0]   req_pos_x,
  input  logic [NUM_INPUTS*NUM_THREADS*DIM_BITS-1:0]   req_pos_y,
  input  logic [NUM_INPUTS*NUM_THREADS*32-1:0]         req_color,
  input  logic [NUM_INPUTS*NUM_THREADS*DEPTH_BITS-1:0] req_depth,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]      req_backface,
  output logic [NUM_INPUTS-1:0]                  req_ready,
  output logic                                   frag_valid,
  output logic [DIM_BITS-1:0]                    frag_pos_x,
  output logic [DIM_BITS-1:0]                    frag_pos_y,
  output logic [31:0]                            frag_color,
  output logic [DEPTH_BITS-1:0]                  frag_depth,
  output logic                                   frag_backface,
  output logic [SRC_BITS-1:0]                    frag_src,
  output logic                                   frag_last,
  input  logic                                   frag_ready
`ifdef ROP_SCHED_PERF_EN
  ,
  output logic [31:0]                            perf_stall_cycles,
  output logic [31:0]                            perf_frag_count
`endif
);

  localparam int XW = NUM_THREADS * DIM_BITS;
  localparam int CW = NUM_THREADS * 32;
  localparam int DW = NUM_THREADS * DEPTH_BITS;

  rop_sched_state_e        r_state, w_state_nxt;
  logic [NUM_THREADS-1:0]  r_pending, w_pending_nxt, w_acc_tmask, w_lane_oh;
  logic [NUM_THREADS-1:0]  r_backface;
  logic [SRC_BITS-1:0]     r_src;
  logic [XW-1:0]           r_pos_x, r_pos_y;
  logic [CW-1:0]           r_color;
  logic [DW-1:0]           r_depth;
  logic [NUM_INPUTS-1:0]   w_grant;
  logic                    w_grant_valid;
  logic [SRC_BITS-1:0]     w_grant_idx;
  logic                    w_serial, w_fire, w_last, w_can_accept;
  rop_frag_t               w_frag;

  assign w_serial     = (r_state == ROP_SCHED_SERIAL);
  assign w_last       = (r_pending != '0) && ((r_pending & (r_pending - NUM_THREADS'(1))) == '0);
  assign w_fire       = w_serial && frag_ready;
  // Reset also blocks grants so no request is acknowledged during the reset cycle.
  assign w_can_accept = !reset && (!w_serial || (w_fire && w_last));
  assign w_lane_oh    = r_pending & (~r_pending + NUM_THREADS'(1));

  rop_req_sched_rr_arbiter #(.N(NUM_INPUTS), .IDX_BITS(SRC_BITS)) u_arb (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_en          (w_can_accept),
    .i_valid       (req_valid),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_acc_tmask   = '0;
    for (int s = 0; s < NUM_INPUTS; s++) begin
      if (w_grant[s]) w_acc_tmask = req_tmask[s*NUM_THREADS +: NUM_THREADS];
    end
    if (w_fire) begin
      w_pending_nxt = r_pending & ~w_lane_oh;
      if (w_last) w_state_nxt = ROP_SCHED_IDLE;
    end
    if (w_grant_valid) begin
      w_pending_nxt = w_acc_tmask;
      w_state_nxt   = (w_acc_tmask != '0) ? ROP_SCHED_SERIAL : ROP_SCHED_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ROP_SCHED_IDLE;
      r_pending  <= '0;
      r_src      <= '0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_color    <= '0;
      r_depth    <= '0;
      r_backface <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_grant_valid) begin
        r_src <= w_grant_idx;
        for (int s = 0; s < NUM_INPUTS; s++) begin
          if (w_grant[s]) begin
            r_pos_x    <= req_pos_x[s*XW +: XW];
            r_pos_y    <= req_pos_y[s*XW +: XW];
            r_color    <= req_color[s*CW +: CW];
            r_depth    <= req_depth[s*DW +: DW];
            r_backface <= req_backface[s*NUM_THREADS +: NUM_THREADS];
          end
        end
      end
    end
  end

  // Pending is empty outside SERIAL, so the lane mux yields zeros there.
  always_comb begin
    w_frag = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (w_lane_oh[i]) begin
        w_frag.pos_x    = r_pos_x[i*DIM_BITS +: DIM_BITS];
        w_frag.pos_y    = r_pos_y[i*DIM_BITS +: DIM_BITS];
        w_frag.color    = r_color[i*32 +: 32];
        w_frag.depth    = r_depth[i*DEPTH_BITS +: DEPTH_BITS];
        w_frag.backface = r_backface[i];
      end
    end
    w_frag.src = w_serial ? r_src : '0;
  end

  assign req_ready     = w_grant;
  assign frag_valid    = w_serial;
  assign frag_pos_x    = w_frag.pos_x;
  assign frag_pos_y    = w_frag.pos_y;
  assign frag_color    = w_frag.color;
  assign frag_depth    = w_frag.depth;
  assign frag_backface = w_frag.backface;
  assign frag_src      = w_frag.src;
  assign frag_last     = w_last;

`ifdef ROP_SCHED_PERF_EN
  logic [31:0] r_perf_stall, r_perf_frag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_frag  <= '0;
    end else begin
      if (w_serial && !frag_ready) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_fire)                  r_perf_frag  <= r_perf_frag + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_frag_count   = r_perf_frag;
`endif

endmodule

// File: tb/tb_rop_req_sched.sv
// Directed bench for rop_req_sched; perf counters are checked when ROP_SCHED_PERF_EN is defined.
module tb_rop_req_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [15:0]  req_tmask;
  logic [191:0] req_pos_x, req_pos_y;
  logic [511:0] req_color;
  logic [383:0] req_depth;
  logic [15:0]  req_backface;
  logic [3:0]   req_ready;
  logic         frag_valid, frag_backface, frag_last, frag_ready;
  logic [11:0]  frag_pos_x, frag_pos_y;
  logic [31:0]  frag_color;
  logic [23:0]  frag_depth;
  logic [1:0]   frag_src;
`ifdef ROP_SCHED_PERF_EN
  logic [31:0]  perf_stall_cycles, perf_frag_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rop_req_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tmask(req_tmask),
    .req_pos_x(req_pos_x), .req_pos_y(req_pos_y), .req_color(req_color),
    .req_depth(req_depth), .req_backface(req_backface), .req_ready(req_ready),
    .frag_valid(frag_valid), .frag_pos_x(frag_pos_x), .frag_pos_y(frag_pos_y),
    .frag_color(frag_color), .frag_depth(frag_depth), .frag_backface(frag_backface),
    .frag_src(frag_src), .frag_last(frag_last), .frag_ready(frag_ready)
`ifdef ROP_SCHED_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_frag_count(perf_frag_count)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int s, input int l, input logic [11:0] x);
    int idx;
    idx = s*4 + l;
    req_pos_x[idx*12 +: 12]  = x;
    req_pos_y[idx*12 +: 12]  = x + 12'h100;
    req_color[idx*32 +: 32]  = 32'hC0DE_0000 | {20'h0, x};
    req_depth[idx*24 +: 24]  = {12'hABC, x};
    req_backface[idx]        = x[0];
  endtask

  task automatic set_mask(input int s, input logic [3:0] m);
    req_tmask[s*4 +: 4] = m;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; frag_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; frag_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frag_valid); end
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_tests++; if ({frag_pos_x, frag_pos_y, frag_color, frag_depth, frag_backface, frag_src, frag_last} !== '0) begin
      n_fail++; $display("FAIL reset_frag_zero: x=%h y=%h c=%h d=%h src=%0d last=%b", frag_pos_x, frag_pos_y, frag_color, frag_depth, frag_src, frag_last); end
`ifdef ROP_SCHED_PERF_EN
    n_tests++; if ({perf_stall_cycles, perf_frag_count} !== 64'h0) begin n_fail++; $display("FAIL reset_perf: stall=%0d frags=%0d want 0", perf_stall_cycles, perf_frag_count); end
`endif
  endtask

  task automatic test_basic_serialise();
    logic [11:0] xs [3];
    logic        ls [3];
    xs[0] = 12'h000; xs[1] = 12'h010; xs[2] = 12'h030;
    ls[0] = 1'b0;    ls[1] = 1'b0;    ls[2] = 1'b1;
    for (int l = 0; l < 4; l++) set_lane(1, l, 12'(l*16));
    set_mask(1, 4'b1011);
    frag_ready = 1'b1; req_valid = 4'b0010; #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL basic_grant: got %b want 0010", req_ready); end
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_frag: got %b want 0", frag_valid); end
    tick(); req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (frag_valid !== 1'b1 || frag_pos_x !== xs[k] || frag_last !== ls[k] || frag_src !== 2'd1) begin
        n_fail++; $display("FAIL basic_frag%0d: v=%b x=%h last=%b src=%0d want v=1 x=%h last=%b src=1", k, frag_valid, frag_pos_x, frag_last, frag_src, xs[k], ls[k]); end
      n_tests++; if (frag_pos_y !== xs[k] + 12'h100 || frag_color !== (32'hC0DE_0000 | {20'h0, xs[k]}) || frag_depth !== {12'hABC, xs[k]} || frag_backface !== xs[k][0]) begin
        n_fail++; $display("FAIL basic_fields%0d: y=%h c=%h d=%h bf=%b for x=%h", k, frag_pos_y, frag_color, frag_depth, frag_backface, xs[k]); end
      tick();
    end
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b want 0", frag_valid); end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] esrc;
    apply_reset();
    set_lane(0, 0, 12'h00A); set_mask(0, 4'b0001);
    set_lane(2, 0, 12'h02A); set_mask(2, 4'b0001);
    req_valid = 4'b0101; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_grant: got %b want 0001", req_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      esrc = (k % 2 == 0) ? 2'd0 : 2'd2;
      if (k == 3) begin req_valid = '0; #1; end
      n_tests++; if (frag_valid !== 1'b1 || frag_src !== esrc || frag_last !== 1'b1 || frag_pos_x !== ((esrc == 2'd0) ? 12'h00A : 12'h02A)) begin
        n_fail++; $display("FAIL rr_frag%0d: v=%b src=%0d x=%h last=%b want src=%0d", k, frag_valid, frag_src, frag_pos_x, frag_last, esrc); end
      n_tests++; if (req_ready !== ((k == 3) ? 4'b0000 : ((esrc == 2'd0) ? 4'b0100 : 4'b0001))) begin
        n_fail++; $display("FAIL rr_ready%0d: got %b after src %0d", k, req_ready, esrc); end
    end
    tick();
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_after: got %b want 0", frag_valid); end
  endtask

  task automatic test_empty_mask();
    set_mask(3, 4'b0000);
    req_valid = 4'b1000; #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL empty_grant: got %b want 1000", req_ready); end
    tick(); req_valid = '0; #1;
    n_tests++; if (frag_valid !== 1'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL empty_no_frag: v=%b rdy=%b want 0/0000", frag_valid, req_ready); end
    tick();
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL empty_still_idle: got %b want 0", frag_valid); end
    set_lane(0, 0, 12'h00B); set_mask(0, 4'b0001); set_mask(3, 4'b0001);
    req_valid = 4'b1001; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL empty_ptr_wrap: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    n_tests++; if (frag_valid !== 1'b1 || frag_pos_x !== 12'h00B || frag_src !== 2'd0) begin
      n_fail++; $display("FAIL empty_next_frag: v=%b x=%h src=%0d want 1/00b/0", frag_valid, frag_pos_x, frag_src); end
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    for (int l = 0; l < 4; l++) set_lane(0, l, 12'(12'h040 + l));
    set_mask(0, 4'b1111);
    req_valid = 4'b0001; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_grant: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    n_tests++; if (frag_pos_x !== 12'h040) begin n_fail++; $display("FAIL stall_lane0: got %h want 040", frag_pos_x); end
    tick();
    frag_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (frag_valid !== 1'b1 || frag_pos_x !== 12'h041 || frag_color !== 32'hC0DE_0041 || frag_last !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: v=%b x=%h c=%h last=%b want 1/041/c0de0041/0", k, frag_valid, frag_pos_x, frag_color, frag_last); end
    end
    frag_ready = 1'b1;
    tick();
    n_tests++; if (frag_pos_x !== 12'h042 || frag_last !== 1'b0) begin n_fail++; $display("FAIL stall_lane2: x=%h last=%b want 042/0", frag_pos_x, frag_last); end
    tick();
    n_tests++; if (frag_pos_x !== 12'h043 || frag_last !== 1'b1) begin n_fail++; $display("FAIL stall_lane3: x=%h last=%b want 043/1", frag_pos_x, frag_last); end
    tick();
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle_after: got %b want 0", frag_valid); end
`ifdef ROP_SCHED_PERF_EN
    n_tests++; if (perf_stall_cycles !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d want 5", perf_stall_cycles); end
    n_tests++; if (perf_frag_count !== 32'd4) begin n_fail++; $display("FAIL perf_frags: got %0d want 4", perf_frag_count); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int l = 0; l < 4; l++) set_lane(0, l, 12'(12'h050 + l));
    set_mask(0, 4'b0111);
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick();
    n_tests++; if (frag_pos_x !== 12'h051) begin n_fail++; $display("FAIL rmid_lane1: got %h want 051", frag_pos_x); end
    reset = 1'b1;
    tick();
    n_tests++; if (frag_valid !== 1'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL rmid_cleared: v=%b rdy=%b want 0/0000", frag_valid, req_ready); end
    reset = 1'b0;
    tick();
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resume: got %b want 0", frag_valid); end
    set_lane(0, 0, 12'h055); set_mask(0, 4'b0001);
    set_lane(3, 0, 12'h03F); set_mask(3, 4'b0001);
    req_valid = 4'b1001; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr_zero: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    n_tests++; if (frag_valid !== 1'b1 || frag_pos_x !== 12'h055 || frag_last !== 1'b1 || frag_src !== 2'd0) begin
      n_fail++; $display("FAIL rmid_serve: v=%b x=%h last=%b src=%0d want 1/055/1/0", frag_valid, frag_pos_x, frag_last, frag_src); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_lane(1, 0, 12'h061); set_mask(1, 4'b0001);
    req_valid = 4'b0010; #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_first_grant: got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    n_tests++; if (frag_pos_x !== 12'h061 || frag_last !== 1'b1) begin n_fail++; $display("FAIL b2b_first_frag: x=%h last=%b want 061/1", frag_pos_x, frag_last); end
    set_lane(2, 2, 12'h072); set_mask(2, 4'b0100);
    req_valid = 4'b0100; #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL b2b_same_cycle_grant: got %b want 0100", req_ready); end
    tick(); req_valid = '0;
    n_tests++; if (frag_valid !== 1'b1 || frag_pos_x !== 12'h072 || frag_src !== 2'd2 || frag_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_bubble: v=%b x=%h src=%0d last=%b want 1/072/2/1", frag_valid, frag_pos_x, frag_src, frag_last); end
    tick();
    n_tests++; if (frag_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 0", frag_valid); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_tmask = '0; req_pos_x = '0; req_pos_y = '0;
    req_color = '0; req_depth = '0; req_backface = '0; frag_ready = 1'b0;
    test_reset();
    test_basic_serialise();
    test_rr_alternate();
    test_empty_mask();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rop_req_sched.md
Name: rop_req_sched

Overview:
- Front-end scheduler for the per-pixel ROP datapath.
- Arbitrates warp-wide ROP requests from NUM_INPUTS cores/sockets (round-robin) and latches one warp entry.
- Serialises the entry's active lanes into single-fragment requests, one per cycle, toward the depth/stencil/blend pipeline.
- Sits between the per-core ROP queues and the ROP memory/datapath stages.

Parameters:
NUM_INPUTS, 4, number of requesting sources
NUM_THREADS, 4, lanes per warp entry
DIM_BITS, 12, pixel coordinate width (= ROP_DIM_BITS)
DEPTH_BITS, 24, depth width (= ROP_DEPTH_BITS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_INPUTS  per-source request valid
req_tmask  in  NUM_INPUTS*NUM_THREADS  lane masks
req_pos_x  in  NUM_INPUTS*NUM_THREADS*DIM_BITS  lane x
req_pos_y  in  NUM_INPUTS*NUM_THREADS*DIM_BITS  lane y
req_color  in  NUM_INPUTS*NUM_THREADS*32  lane RGBA (a,r,g,b byte order, MSB first)
req_depth  in  NUM_INPUTS*NUM_THREADS*DEPTH_BITS  lane depth
req_backface  in  NUM_INPUTS*NUM_THREADS  lane backface flag
req_ready  out  NUM_INPUTS  per-source accept (one-hot or zero)
frag_valid  out  1  fragment valid
frag_pos_x  out  DIM_BITS  fragment x
frag_pos_y  out  DIM_BITS  fragment y
frag_color  out  32  fragment color
frag_depth  out  DEPTH_BITS  fragment depth
frag_backface  out  1  fragment backface
frag_src  out  clog2(NUM_INPUTS) (min 1)  originating source index
frag_last  out  1  final active lane of entry
frag_ready  in  1  downstream accept

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high.
- Reset: state=IDLE, rr_ptr=0, pending mask=0, buffered entry=0; frag_valid=0, all frag_* outputs=0, req_ready=0.
- States: IDLE, SERIAL.
- can_accept = (state==IDLE) || (state==SERIAL && frag_valid && frag_ready && frag_last).
- Grant: when can_accept, select the first set req_valid starting at rr_ptr, wrapping modulo NUM_INPUTS.
  - req_ready is one-hot on the granted source, combinational from req_valid, rr_ptr and state; otherwise 0.
  - Sources must hold request fields stable while valid and unaccepted.
- On accept from source g: latch tmask, lane fields and g; set rr_ptr=(g+1) mod NUM_INPUTS.
  - tmask != 0: next state SERIAL.
  - tmask == 0: entry consumed with no fragment emitted; state IDLE (or returns to IDLE if last fragment also fired); rr_ptr still advances.
- Latency: accept in cycle N → first frag_valid in cycle N+1; registered outputs.
- SERIAL:
  - frag_valid=1; lane = lowest set bit of the pending mask; frag_* driven from that lane.
  - frag_last=1 iff popcount(pending)==1.
  - On frag_valid && frag_ready: clear lane bit. If last and no new accept that cycle → IDLE.
  - If last and a non-empty entry is accepted that cycle → stay SERIAL with the new entry (zero-bubble).
- Stall: frag_* hold stable while frag_valid && !frag_ready.
- Throughput: popcount(tmask) cycles per entry at full downstream rate.
- Reset mid-entry: pending lanes discarded, no fragment emitted after reset cycle.
- No request valid in IDLE: remain IDLE, rr_ptr unchanged.

Optional Feature:
- Macro: ROP_SCHED_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with frag_valid && !frag_ready) and perf_frag_count[31:0] (fragment handshakes).
  - Both zero on reset; wrap modulo 2^32.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- rop_types package gains:
  - rop_frag_t struct (pos_x, pos_y, color, depth, backface, src).
  - State enum (ROP_SCHED_IDLE, ROP_SCHED_SERIAL).
  - Reuse of ROP_DIM_BITS / ROP_DEPTH_BITS constants.
- One sub-module: rop_rr_arbiter (combinational round-robin grant from valid + ptr, with ptr update on accept); serialisation kept in top.

Test Plan:
- Reset, then source 1 sends tmask=4'b1011, x={0x30,0x20,0x10,0x00}, frag_ready=1 → cycles N+1..N+3 emit x=0x00,0x10,0x30; frag_last only on third; frag_src=1.
- Sources 0 and 2 both valid continuously, tmask=4'b0001 each, rr_ptr=0 → grants alternate 0,2,0,2 with no idle cycle between fragments.
- tmask=0 from source 3 → req_ready[3]=1 for one cycle, frag_valid stays 0, rr_ptr becomes 0.
- tmask=4'b1111, frag_ready low for 5 cycles after first fragment → frag_x/color held constant; with ROP_SCHED_PERF_EN, perf_stall_cycles=5 and perf_frag_count=4 at end.
- Assert reset while 2 lanes pending → next cycle frag_valid=0, req_ready=0, rr_ptr=0; subsequent request served normally.
- Last fragment handshake coincides with new valid request tmask=4'b0100 → accepted same cycle, its fragment appears next cycle (no bubble).
